// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin front end sharing one CORDIC sin/cos core.
// One request in flight; result returned on a tagged valid/ready channel.
module cordic_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ITER    = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_angle,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  core_start,
  output logic [31:0]           core_angle,
  input  logic [31:0]           core_sin,
  input  logic [31:0]           core_cos,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sin,
  output logic [31:0]           rsp_cos,
  output logic                  busy,
  output logic [15:0]           op_count
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   idx;
  logic              found;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic [31:0]       sel_angle;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign sel_angle  = req_angle[{grant, 5'd0} +: 32];
  assign last       = (cnt == CNT_W'(ITER - 1));
  assign core_start = (state == START);
  assign busy       = (state != IDLE);
  assign req_ready  = (state == IDLE && found)
                    ? (NUM_REQ'(1) << grant) : '0;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (found) state_next = START;
      START: state_next = RUN;
      RUN:   if (last) state_next = RESP;
      RESP:  if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      core_angle <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sin    <= '0;
      rsp_cos    <= '0;
      op_count   <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (found) begin
            core_angle <= sel_angle;
            rsp_id     <= grant;
            rr_ptr     <= grant;
          end
        end
        START: cnt <= '0;
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            rsp_sin   <= core_sin;
            rsp_cos   <= core_cos;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: scoreboard bench with a behavioural CORDIC core
// whose outputs are only meaningful on the final iteration.
module tb_cordic_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ITER    = 16;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [32*NUM_REQ-1:0] req_angle = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  core_start;
  logic [31:0]           core_angle;
  logic [31:0]           core_sin;
  logic [31:0]           core_cos;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sin;
  logic [31:0]           rsp_cos;
  logic                  busy;
  logic [15:0]           op_count;

  cordic_arbiter #(.NUM_REQ(NUM_REQ), .ITER(ITER), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .core_start(core_start), .core_angle(core_angle),
    .core_sin(core_sin), .core_cos(core_cos),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     s;
    logic [31:0]     c;
  } rsp_t;

  function automatic logic [31:0] fs(input logic [31:0] a);
    if (a == 32'h3F060A92) return 32'h3F000000;
    if (a == 32'hBF060A92) return 32'hBF000000;
    return a ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] fc(input logic [31:0] a);
    if (a == 32'h3F060A92 || a == 32'hBF060A92) return 32'h3F5DB3D7;
    return {a[15:0], a[31:16]} + 32'd1;
  endfunction

  // Core model: iteration index restarts on start; final values only at ITER-1.
  int it = 1000;
  always @(posedge clk) begin
    if (core_start) it <= 0;
    else if (it < 1000) it <= it + 1;
  end
  assign core_sin = (it == ITER - 1) ? fs(core_angle) : (32'hDEAD0000 | 32'(it));
  assign core_cos = (it == ITER - 1) ? fc(core_angle) : (32'hBEEF0000 | 32'(it));

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   gq[$];
  int   remaining[NUM_REQ];
  logic [31:0] ang[NUM_REQ];
  int   cyc, t_grant, t_lg, t_start, t_rsp, n_start, n_ready;
  logic [NUM_REQ-1:0] first_grant;
  int   checks = 0;
  int   errors = 0;
  rsp_t o, e;

  task automatic step();
    logic [NUM_REQ-1:0] g;
    @(negedge clk);
    cyc++;
    g = req_ready;
    if (!rst) begin
      if (g != 0) begin
        n_ready++;
        t_lg = cyc;
        if (t_grant < 0) begin
          t_grant = cyc;
          first_grant = g;
        end
      end
      if (core_start) begin
        n_start++;
        if (t_start < 0) t_start = cyc;
      end
      if (rsp_valid && t_rsp < 0) t_rsp = cyc;
      if (rsp_valid && rsp_ready)
        obs_q.push_back(rsp_t'({rsp_id, rsp_sin, rsp_cos}));
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g[k]) begin
          exp_q.push_back(rsp_t'({ID_W'(k), fs(ang[k]), fc(ang[k])}));
          gq.push_back(k);
          remaining[k]--;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid[k] = remaining[k] > 0;
      req_angle[32*k +: 32] = ang[k];
    end
  endtask

  task automatic clear_stats();
    exp_q.delete();
    obs_q.delete();
    gq.delete();
    t_grant = -1;
    t_lg = -1;
    t_start = -1;
    t_rsp = -1;
    n_start = 0;
    n_ready = 0;
    first_grant = '0;
  endtask

  task automatic do_reset();
    for (int k = 0; k < NUM_REQ; k++) remaining[k] = 0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    for (int k = 0; k < NUM_REQ; k++) begin
      remaining[k] = 0;
      ang[k] = '0;
    end
    rst = 1'b1;
    step();
    step();
    checks += 9;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    if (rsp_sin !== '0) begin errors++; $display("FAIL reset_rsp_sin got %h want 0", rsp_sin); end
    if (rsp_cos !== '0) begin errors++; $display("FAIL reset_rsp_cos got %h want 0", rsp_cos); end
    if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got %b want 0", core_start); end
    if (core_angle !== '0) begin errors++; $display("FAIL reset_core_angle got %h want 0", core_angle); end
    if (op_count !== '0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic test_single();
    do_reset();
    ang[2] = 32'h3F060A92;
    remaining[2] = 1;
    for (int i = 0; i < 40 && obs_q.size() < 1; i++) step();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL single_timeout got %0d responses want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks += 3;
      if (o.id !== 2'd2) begin errors++; $display("FAIL single_id got %0d want 2", o.id); end
      if (o.s !== 32'h3F000000) begin errors++; $display("FAIL single_sin got %h want 3f000000", o.s); end
      if (o.c !== 32'h3F5DB3D7) begin errors++; $display("FAIL single_cos got %h want 3f5db3d7", o.c); end
    end
    checks += 6;
    if (first_grant !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", first_grant); end
    if (n_ready !== 1) begin errors++; $display("FAIL single_ready_cycles got %0d want 1", n_ready); end
    if (n_start !== 1) begin errors++; $display("FAIL single_start_cycles got %0d want 1", n_start); end
    if (t_start !== t_grant + 1) begin errors++; $display("FAIL single_start_time got %0d want %0d", t_start, t_grant + 1); end
    if (t_rsp !== t_grant + ITER + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", t_rsp - t_grant, ITER + 2); end
    if (op_count !== 16'd1) begin errors++; $display("FAIL single_op_count got %0d want 1", op_count); end
  endtask

  task automatic test_all_four();
    do_reset();
    ang[0] = 32'h3E800000;
    ang[1] = 32'h3F000000;
    ang[2] = 32'h3F400000;
    ang[3] = 32'h3F800000;
    for (int k = 0; k < NUM_REQ; k++) remaining[k] = 1;
    for (int i = 0; i < 120 && obs_q.size() < 4; i++) step();
    checks++;
    if (obs_q.size() != 4 || gq.size() != 4) begin
      errors++;
      $display("FAIL four_count got %0d/%0d want 4", obs_q.size(), gq.size());
    end
    for (int i = 0; i < gq.size(); i++) begin
      checks++;
      if (gq[i] !== i) begin errors++; $display("FAIL four_order[%0d] got %0d want %0d", i, gq[i], i); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL four_rsp got %h want %h", o, e); end
    end
    checks += 2;
    if (op_count !== 16'd4) begin errors++; $display("FAIL four_op_count got %0d want 4", op_count); end
    if (t_lg - t_grant !== 3 * (ITER + 3)) begin
      errors++;
      $display("FAIL four_throughput got %0d want %0d", t_lg - t_grant, 3 * (ITER + 3));
    end
  endtask

  task automatic test_alternate();
    do_reset();
    ang[0] = 32'h3DCCCCCD;
    ang[2] = 32'h3FC90FDB;
    remaining[0] = 1000;
    remaining[2] = 1000;
    for (int i = 0; i < 200 && gq.size() < 6; i++) step();
    remaining[0] = 0;
    remaining[2] = 0;
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) step();
    checks++;
    if (gq.size() != 6) begin errors++; $display("FAIL alt_count got %0d want 6", gq.size()); end
    for (int i = 0; i < gq.size(); i++) begin
      checks++;
      if (gq[i] !== (i % 2) * 2) begin
        errors++;
        $display("FAIL alt_order[%0d] got %0d want %0d", i, gq[i], (i % 2) * 2);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL alt_rsp got %h want %h", o, e); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    ang[1] = 32'h40000000;
    remaining[1] = 1;
    for (int i = 0; i < 40 && !rsp_valid; i++) step();
    ang[0] = 32'h3F800000;
    ang[3] = 32'h3E000000;
    remaining[0] = 1;
    remaining[3] = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks += 4;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", rsp_valid); end
      if ({rsp_id, rsp_sin, rsp_cos} !== {2'd1, fs(32'h40000000), fc(32'h40000000)}) begin
        errors++;
        $display("FAIL bp_hold got %0d %h %h want 1 %h %h", rsp_id, rsp_sin, rsp_cos,
                 fs(32'h40000000), fc(32'h40000000));
      end
      if (req_ready !== '0) begin errors++; $display("FAIL bp_req_ready got %b want 0", req_ready); end
      if (core_start !== 1'b0) begin errors++; $display("FAIL bp_core_start got %b want 0", core_start); end
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL bp_release got %0d responses want 1", obs_q.size()); end
    for (int i = 0; i < 100 && obs_q.size() < 3; i++) step();
    checks++;
    if (gq.size() != 3) begin errors++; $display("FAIL bp_grants got %0d want 3", gq.size()); end
    else begin
      checks++;
      if (gq[0] !== 1 || gq[1] !== 3 || gq[2] !== 0) begin
        errors++;
        $display("FAIL bp_order got %0d,%0d,%0d want 1,3,0", gq[0], gq[1], gq[2]);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL bp_rsp got %h want %h", o, e); end
    end
    checks++;
    if (op_count !== 16'd3) begin errors++; $display("FAIL bp_op_count got %0d want 3", op_count); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    ang[1] = 32'h3F400000;
    remaining[1] = 1;
    for (int i = 0; i < 40 && obs_q.size() < 1; i++) step();
    clear_stats();
    ang[0] = 32'h3F800000;
    remaining[0] = 1;
    for (int i = 0; i < 10 && t_start < 0; i++) step();
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    checks += 7;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
    if (core_angle !== '0) begin errors++; $display("FAIL mid_core_angle got %h want 0", core_angle); end
    if (core_start !== 1'b0) begin errors++; $display("FAIL mid_core_start got %b want 0", core_start); end
    if (rsp_id !== '0) begin errors++; $display("FAIL mid_rsp_id got %0d want 0", rsp_id); end
    if (rsp_sin !== '0 || rsp_cos !== '0) begin
      errors++;
      $display("FAIL mid_rsp_data got %h %h want 0 0", rsp_sin, rsp_cos);
    end
    if (op_count !== '0) begin errors++; $display("FAIL mid_op_count got %0d want 0", op_count); end
    rst = 1'b0;
    clear_stats();
    ang[3] = 32'h3F060A92;
    remaining[3] = 1;
    for (int i = 0; i < 40 && obs_q.size() < 1; i++) step();
    for (int i = 0; i < 25; i++) step();
    checks += 2;
    if (obs_q.size() != 1) begin errors++; $display("FAIL mid_rsp_count got %0d want 1", obs_q.size()); end
    if (n_start !== 1) begin errors++; $display("FAIL mid_start_count got %0d want 1", n_start); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (o !== rsp_t'({2'd3, 32'h3F000000, 32'h3F5DB3D7})) begin
        errors++;
        $display("FAIL mid_rsp got %h want 3 3f000000 3f5db3d7", o);
      end
    end
  endtask

  task automatic test_negative();
    do_reset();
    ang[1] = 32'hBF060A92;
    remaining[1] = 1;
    for (int i = 0; i < 10 && t_start < 0; i++) step();
    for (int i = 0; i < ITER + 4 && !rsp_valid; i++) begin
      checks++;
      if (core_angle !== 32'hBF060A92) begin
        errors++;
        $display("FAIL neg_angle_run got %h want bf060a92", core_angle);
      end
      step();
    end
    for (int i = 0; i < 5 && obs_q.size() < 1; i++) step();
    checks += 2;
    if (core_angle !== 32'hBF060A92) begin errors++; $display("FAIL neg_angle_after got %h want bf060a92", core_angle); end
    if (obs_q.size() != 1) begin errors++; $display("FAIL neg_count got %0d want 1", obs_q.size()); end
    else begin
      o = obs_q.pop_front();
      checks++;
      if (o !== rsp_t'({2'd1, 32'hBF000000, 32'h3F5DB3D7})) begin
        errors++;
        $display("FAIL neg_rsp got %h want 1 bf000000 3f5db3d7", o);
      end
    end
  endtask

  initial begin
    cyc = 0;
    clear_stats();
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_backpressure();
    test_reset_mid_run();
    test_negative();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
